gb_cpu_idu_bank: RTL and testbench
==================================

Name: gb_cpu_idu_bank

Overview:
- Registered, multi-channel successor to the CPU's 16-bit increment/decrement unit.
- Holds NUM_CH pointer registers (e.g. PC, SP, HL, DMA source) and applies NOP/INC/DEC/LOAD to one channel per accepted request.
- Returns pre- and post-op values through a one-deep valid/ready response stage; the pre-op value drives the address bus, the post-op value is written back.
- Sits between the CPU control sequencer and the register file/address mux.

Parameters:
- WIDTH, 16, pointer width in bits (>=2).
- NUM_CH, 4, number of pointer channels (>=1).
- RESET_VAL, 0, reset value of every channel register (WIDTH bits).
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived channel-index width; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_ch  in  CH_W  target channel.
- req_op  in  2  00 NOP, 01 INC, 10 DEC, 11 LOAD.
- req_data  in  WIDTH  load value, used only for LOAD.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_ch  out  CH_W  channel of the response.
- rsp_pre  out  WIDTH  channel value before the op.
- rsp_post  out  WIDTH  channel value after the op.
- rsp_wrap  out  1  INC from all-ones or DEC from zero.
- rsp_err  out  1  req_ch >= NUM_CH.
- rd_ch  in  CH_W  combinational read select.
- rd_data  out  WIDTH  current (committed) value of channel rd_ch; 0 if rd_ch >= NUM_CH.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - All channels = RESET_VAL.
  - rsp_valid=0; rsp_ch, rsp_pre, rsp_post, rsp_wrap, rsp_err = 0.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready, so full throughput with no bubble when rsp_ready=1.
  - req_ready must not depend on req_valid.
- Accept cycle: the channel register commits the new value at the same edge that loads the response stage. Latency is 1 cycle from acceptance to rsp_valid.
- Response stability: while rsp_valid && !rsp_ready, all rsp_* outputs hold and req_ready=0.
- If there is no accept and the response is consumed, rsp_valid falls to 0.
- Arithmetic is modulo 2^WIDTH:
  - INC: post=pre+1.
  - DEC: post=pre-1.
  - NOP: post=pre.
  - LOAD: post=req_data.
- rsp_wrap = (INC && pre==all-ones) || (DEC && pre==0). It is 0 for NOP and LOAD.
- Back-to-back requests to the same channel: the second sees the first's committed post value. No stale reads, since commit happens on accept.
- Invalid channel (req_ch >= NUM_CH):
  - Request is accepted; no register changes.
  - rsp_err=1, rsp_pre=rsp_post=0, rsp_wrap=0.
- rd_data is combinational from the registers. On the accept edge it returns the old value; the new value is visible the following cycle.
- Reset mid-operation: a pending response is discarded (rsp_valid=0) and registers return to RESET_VAL.
- There is no X propagation: every req_op encoding is defined.

Optional Feature:
- Macro: GB_CPU_IDU_SATURATE_EN.
- Defined:
  - INC at all-ones keeps all-ones; DEC at zero keeps zero.
  - rsp_wrap still asserts to flag the attempted overflow/underflow.
  - rsp_post reports the saturated value.
- Undefined: modulo wrap as above.

Test Plan:
- Reset, WIDTH=16, NUM_CH=4, RESET_VAL=0x0100 -> rd_data=0x0100 for channels 0-3; rsp_valid=0; req_ready=1.
- LOAD ch1 0xFFFF, then INC ch1 back-to-back with rsp_ready=1 -> responses (pre 0x0100, post 0xFFFF, wrap 0) then (pre 0xFFFF, post 0x0000, wrap 1); rd_data(ch1)=0x0000 afterwards. With GB_CPU_IDU_SATURATE_EN: post 0xFFFF, wrap 1.
- DEC ch2 from 0x0000 -> pre 0x0000, post 0xFFFF, wrap 1, rsp_ch=2.
- Backpressure: INC ch0 accepted, rsp_ready=0 for 3 cycles while req_valid=1 (INC ch0) -> req_ready=0, rsp_* stable, ch0 incremented once. Release -> second INC accepted, ch0 = RESET_VAL+2.
- req_ch=3 with NUM_CH=3, op INC -> rsp_err=1, rsp_pre=rsp_post=0, no channel changes.
- Assert rst_n=0 asynchronously while rsp_valid=1 -> rsp_valid drops immediately, channels return to RESET_VAL.

Source files
------------

// File: rtl/gb_cpu_idu_bank.sv
// -----------------------------------------------------------------------------
// gb_cpu_idu_bank
// Multi-channel registered increment/decrement unit. It holds NUM_CH pointer
// registers (PC, SP, HL, DMA source, ...). Each accepted request applies
// NOP/INC/DEC/LOAD to one channel. The pre-op and post-op values come back
// through a one-deep valid/ready response stage.
//
// Optional feature macro: GB_CPU_IDU_SATURATE_EN
//   When defined, INC at all-ones and DEC at zero saturate instead of
//   wrapping. rsp_wrap still flags the attempted overflow or underflow.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_ch               target channel
//   req_op               00 NOP, 01 INC, 10 DEC, 11 LOAD
//   req_data             load value, used only for LOAD
//   rsp_valid/rsp_ready  response handshake
//   rsp_ch               channel of the response
//   rsp_pre/rsp_post     channel value before and after the op
//   rsp_wrap             INC from all-ones or DEC from zero
//   rsp_err              request named a channel >= NUM_CH
//   rd_ch/rd_data        combinational read of a committed channel value
// -----------------------------------------------------------------------------
module gb_cpu_idu_bank #(
  parameter int               WIDTH     = 16,
  parameter int               NUM_CH    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [1:0]        req_op,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CH_W-1:0]   rsp_ch,
  output logic [WIDTH-1:0]  rsp_pre,
  output logic [WIDTH-1:0]  rsp_post,
  output logic              rsp_wrap,
  output logic              rsp_err,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // One extra bit so that NUM_CH itself is representable when it is a power of two.
  localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W+1)'(NUM_CH);

`ifdef GB_CPU_IDU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH-1:0] ch_r [NUM_CH];

  logic             rsp_valid_r;
  logic [CH_W-1:0]  rsp_ch_r;
  logic [WIDTH-1:0] rsp_pre_r;
  logic [WIDTH-1:0] rsp_post_r;
  logic             rsp_wrap_r;
  logic             rsp_err_r;

  logic             ch_ok_s;
  logic             accept_s;
  logic [WIDTH-1:0] pre_s;
  logic [WIDTH-1:0] arith_post_s;
  logic             arith_wrap_s;
  logic [WIDTH-1:0] post_s;
  logic             wrap_s;

  // The response slot frees up when it is empty or drained this cycle. This term never looks at req_valid.
  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready;

  // Read the selected channel and compute the op result. Out-of-range channels read as zero.
  always_comb begin
    ch_ok_s      = ({1'b0, req_ch} < NUM_CH_EXT);
    pre_s        = ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      pre_s = (req_ch == CH_W'(i)) ? ch_r[i] : pre_s;
    end
    arith_post_s = pre_s;
    arith_wrap_s = 1'b0;
    case (req_op)
      OP_NOP: begin
        arith_post_s = pre_s;
        arith_wrap_s = 1'b0;
      end
      OP_INC: begin
        arith_wrap_s = (pre_s == ALL_ONES);
        arith_post_s = (arith_wrap_s && SAT) ? pre_s : (pre_s + ONE);
      end
      OP_DEC: begin
        arith_wrap_s = (pre_s == ZERO);
        arith_post_s = (arith_wrap_s && SAT) ? pre_s : (pre_s - ONE);
      end
      OP_LOAD: begin
        arith_post_s = req_data;
        arith_wrap_s = 1'b0;
      end
      default: begin
        arith_post_s = pre_s;
        arith_wrap_s = 1'b0;
      end
    endcase
    post_s = ch_ok_s ? arith_post_s : ZERO;
    wrap_s = ch_ok_s ? arith_wrap_s : 1'b0;
  end

  // Channel registers commit on the accept edge, so the next request already sees the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_r[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_s && ch_ok_s && (req_ch == CH_W'(i))) begin
          ch_r[i] <= post_s;
        end
      end
    end
  end

  // One-deep response stage. It holds while stalled and empties when drained with no new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_ch_r    <= {CH_W{1'b0}};
      rsp_pre_r   <= ZERO;
      rsp_post_r  <= ZERO;
      rsp_wrap_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_ch_r    <= req_ch;
      rsp_pre_r   <= pre_s;
      rsp_post_r  <= post_s;
      rsp_wrap_r  <= wrap_s;
      rsp_err_r   <= !ch_ok_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Combinational read port of the committed channel values. Out-of-range selects read as zero.
  always_comb begin
    rd_data = ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data = (rd_ch == CH_W'(i)) ? ch_r[i] : rd_data;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_ch    = rsp_ch_r;
  assign rsp_pre   = rsp_pre_r;
  assign rsp_post  = rsp_post_r;
  assign rsp_wrap  = rsp_wrap_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_gb_cpu_idu_bank.sv
// -----------------------------------------------------------------------------
// tb_gb_cpu_idu_bank
// Self-checking bench for gb_cpu_idu_bank with WIDTH=16, NUM_CH=3 and
// RESET_VAL=0x0100. Channel index 3 is therefore an invalid channel.
// The bench runs a directed vector table, hand-written backpressure and reset
// sequences, and then randomized traffic checked against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_gb_cpu_idu_bank;

  localparam int WIDTH  = 16;
  localparam int NUM_CH = 3;
  localparam int RV     = 'h0100;

`ifdef GB_CPU_IDU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ch;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_ch;
  logic [15:0] rsp_pre;
  logic [15:0] rsp_post;
  logic        rsp_wrap;
  logic        rsp_err;
  logic [1:0]  rd_ch;
  logic [15:0] rd_data;

  gb_cpu_idu_bank #(
    .WIDTH(WIDTH),
    .NUM_CH(NUM_CH),
    .RESET_VAL(16'h0100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ch(rsp_ch), .rsp_pre(rsp_pre), .rsp_post(rsp_post),
    .rsp_wrap(rsp_wrap), .rsp_err(rsp_err),
    .rd_ch(rd_ch), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] pre;
    logic [15:0] post;
    logic        wrap;
    logic        err;
  } vec_t;

  vec_t tbl [9];

  // Reference model: committed channel values plus the pending response.
  int mch [NUM_CH];
  bit m_valid;
  int m_ch, m_pre, m_post;
  bit m_wrap, m_err;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) mch[i] = RV;
    m_valid = 1'b0;
  endtask

  // Called just before a rising edge, using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    int p;
    int n;
    acc = req_valid && (!m_valid || rsp_ready);
    if (acc) begin
      m_valid = 1'b1;
      m_ch    = req_ch;
      if (int'(req_ch) >= NUM_CH) begin
        m_err = 1'b1; m_pre = 0; m_post = 0; m_wrap = 1'b0;
      end else begin
        p = mch[req_ch];
        n = p;
        m_err  = 1'b0;
        m_wrap = 1'b0;
        case (req_op)
          2'd0: n = p;
          2'd1: begin
            n = p + 1;
            if (n == 65536) begin m_wrap = 1'b1; n = SAT ? p : 0; end
          end
          2'd2: begin
            n = p - 1;
            if (n < 0) begin m_wrap = 1'b1; n = SAT ? p : 65535; end
          end
          default: n = int'(req_data);
        endcase
        m_pre  = p;
        m_post = n;
        mch[req_ch] = n;
      end
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_ch = 2'd0; req_op = 2'd0;
    req_data = 16'h0000; rsp_ready = 1'b0; rd_ch = 2'd0;

    // Directed vectors, applied back-to-back with rsp_ready held at 1.
    tbl[0] = '{2'd1, 2'b11, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, 1'b0};
    tbl[1] = '{2'd1, 2'b01, 16'h0000, 16'hFFFF, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 2'b11, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{2'd2, 2'b10, 16'h5555, 16'h0000, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 2'b01, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{2'd0, 2'b00, 16'hAAAA, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[6] = '{2'd0, 2'b11, 16'h1234, 16'h0100, 16'h1234, 1'b0, 1'b0};
    tbl[7] = '{2'd0, 2'b10, 16'h0000, 16'h1234, 16'h1233, 1'b0, 1'b0};
    tbl[8] = '{2'd1, 2'b01, 16'h0000, SAT ? 16'hFFFF : 16'h0000,
               SAT ? 16'hFFFF : 16'h0001, SAT, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_ch",    32'(rsp_ch),    32'd0);
    chk("reset_rsp_pre",   32'(rsp_pre),   32'd0);
    chk("reset_rsp_post",  32'(rsp_post),  32'd0);
    chk("reset_rsp_wrap",  32'(rsp_wrap),  32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      chk($sformatf("reset_rd_ch%0d", i), 32'(rd_data), (i < NUM_CH) ? 32'(RV) : 32'd0);
    end
    @(posedge clk); #1;

    // Table-driven directed sequence.
    for (int v = 0; v < 9; v++) begin
      req_valid = 1'b1; rsp_ready = 1'b1;
      req_ch = tbl[v].ch; req_op = tbl[v].op; req_data = tbl[v].data;
      #1;
      chk($sformatf("tbl%0d_req_ready", v), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rsp_valid", v), 32'(rsp_valid), 32'd1);
      chk($sformatf("tbl%0d_rsp_ch", v),    32'(rsp_ch),    32'(tbl[v].ch));
      chk($sformatf("tbl%0d_rsp_pre", v),   32'(rsp_pre),   32'(tbl[v].pre));
      chk($sformatf("tbl%0d_rsp_post", v),  32'(rsp_post),  32'(tbl[v].post));
      chk($sformatf("tbl%0d_rsp_wrap", v),  32'(rsp_wrap),  32'(tbl[v].wrap));
      chk($sformatf("tbl%0d_rsp_err", v),   32'(rsp_err),   32'(tbl[v].err));
      rd_ch = tbl[v].ch;
      #1;
      chk($sformatf("tbl%0d_rd_data", v), 32'(rd_data), tbl[v].err ? 32'd0 : 32'(tbl[v].post));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("tbl_drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Back to reset values before the backpressure sequence.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure: the first INC is accepted, then the response stalls for 3 cycles.
    req_valid = 1'b1; req_ch = 2'd0; req_op = 2'b01; rsp_ready = 1'b1;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_first_pre",  32'(rsp_pre),  32'h0100);
    chk("bp_first_post", 32'(rsp_post), 32'h0101);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_stall%0d_req_ready", c), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp_stall%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_stall%0d_rsp_ch", c),    32'(rsp_ch),    32'd0);
      chk($sformatf("bp_stall%0d_rsp_pre", c),   32'(rsp_pre),   32'h0100);
      chk($sformatf("bp_stall%0d_rsp_post", c),  32'(rsp_post),  32'h0101);
      rd_ch = 2'd0;
      #1;
      chk($sformatf("bp_stall%0d_rd_ch0", c), 32'(rd_data), 32'h0101);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_pre",  32'(rsp_pre),  32'h0101);
    chk("bp_second_post", 32'(rsp_post), 32'h0102);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_final_rd_ch0",    32'(rd_data),   32'h0102);

    // Asynchronous reset while a response is pending.
    req_valid = 1'b1; req_ch = 2'd2; req_op = 2'b11; req_data = 16'hBEEF; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_rsp_valid_before", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid_after", 32'(rsp_valid), 32'd0);
    rd_ch = 2'd2;
    #1;
    chk("mid_rd_ch2", 32'(rd_data), 32'h0100);
    rd_ch = 2'd0;
    #1;
    chk("mid_rd_ch0", 32'(rd_data), 32'h0100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic checked against the reference model.
    for (int n = 0; n < 2000; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_ch    = 2'($urandom_range(0, 3));
      req_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       req_data = 16'h0000;
        1:       req_data = 16'hFFFF;
        default: req_data = 16'($urandom);
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      rd_ch     = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
      chk("rnd_rd_data", 32'(rd_data), (int'(rd_ch) < NUM_CH) ? 32'(mch[rd_ch]) : 32'd0);
      model_edge();
      @(posedge clk); #1;
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_rsp_ch",   32'(rsp_ch),   32'(m_ch));
        chk("rnd_rsp_pre",  32'(rsp_pre),  32'(m_pre));
        chk("rnd_rsp_post", 32'(rsp_post), 32'(m_post));
        chk("rnd_rsp_wrap", 32'(rsp_wrap), 32'(m_wrap));
        chk("rnd_rsp_err",  32'(rsp_err),  32'(m_err));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
